// File: rtl/repeat_nfa_match_report.sv
// Per-packet match reporter: folds registered branch match bits into a hit mask,
// saturating hit count and earliest-hit position, then offers one record per packet.
module repeat_nfa_match_report #(
    parameter int unsigned NUM_BRANCH = 4,
    parameter int unsigned BR_W       = 2,
    parameter int unsigned OFFSET_W   = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  sop,
    input  logic                  eop,
    input  logic [NUM_BRANCH-1:0] branch_match,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [NUM_BRANCH-1:0] res_hit_mask,
    output logic [BR_W-1:0]       res_first_branch,
    output logic [OFFSET_W-1:0]   res_first_offset,
    output logic [CNT_W-1:0]      res_hit_count,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic                  proto_err
);

    localparam int unsigned PC_W  = 5;
    localparam int unsigned SUM_W = CNT_W + PC_W;

    typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_d_en, r_d_sop, r_d_eop;
    logic [NUM_BRANCH-1:0] r_mask, w_mask_nxt, w_base_mask;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt, w_base_cnt;
    logic                  r_found, w_found_nxt, w_base_found;
    logic [BR_W-1:0]       r_first_br, w_first_br_nxt, w_base_br;
    logic [OFFSET_W-1:0]   r_first_off, w_first_off_nxt, w_base_off;
    logic [OFFSET_W-1:0]   r_off, w_off_nxt, w_cur_off;
    logic [PC_W-1:0]       w_pc;
    logic [SUM_W-1:0]      w_sum;
    logic                  w_start, w_open, w_take, w_close, w_load, w_perr, w_valid_nxt;
    logic [CNT_W-1:0]      w_drop_nxt;

    function automatic logic [PC_W-1:0] f_popcount(input logic [NUM_BRANCH-1:0] v);
        f_popcount = '0;
        for (int i = 0; i < int'(NUM_BRANCH); i++) f_popcount = f_popcount + PC_W'(v[i]);
    endfunction

    function automatic logic [BR_W-1:0] f_lowest(input logic [NUM_BRANCH-1:0] v);
        f_lowest = '0;
        for (int i = int'(NUM_BRANCH) - 1; i >= 0; i--) if (v[i]) f_lowest = BR_W'(i);
    endfunction

    // Next-state, accumulator and result-slot decisions for the delayed byte
    always_comb begin
        w_state_nxt     = r_state;
        w_mask_nxt      = r_mask;
        w_cnt_nxt       = r_cnt;
        w_found_nxt     = r_found;
        w_first_br_nxt  = r_first_br;
        w_first_off_nxt = r_first_off;
        w_off_nxt       = r_off;
        w_close         = 1'b0;

        w_pc    = f_popcount(branch_match);
        w_start = r_d_en & r_d_sop;
        w_open  = (r_state == ST_ACCUM);
        w_take  = r_d_en & (r_d_sop | w_open);

        w_cur_off    = w_start ? '0 : ((&r_off) ? r_off : r_off + OFFSET_W'(1));
        // A new sop (legal or not) restarts accumulation from a clean slate
        w_base_mask  = w_start ? '0 : r_mask;
        w_base_cnt   = w_start ? '0 : r_cnt;
        w_base_found = w_start ? 1'b0 : r_found;
        w_base_br    = w_start ? '0 : r_first_br;
        w_base_off   = w_start ? '0 : r_first_off;
        w_sum        = SUM_W'(w_base_cnt) + SUM_W'(w_pc);

        if (w_take) begin
            w_mask_nxt      = w_base_mask | branch_match;
            w_cnt_nxt       = (w_sum[SUM_W-1:CNT_W] != '0) ? '1 : w_sum[CNT_W-1:0];
            w_found_nxt     = w_base_found;
            w_first_br_nxt  = w_base_br;
            w_first_off_nxt = w_base_off;
            w_off_nxt       = w_cur_off;
            if (!w_base_found && (|branch_match)) begin
                w_found_nxt     = 1'b1;
                w_first_br_nxt  = f_lowest(branch_match);
                w_first_off_nxt = w_cur_off;
            end
            w_state_nxt = r_d_eop ? ST_IDLE : ST_ACCUM;
            w_close     = r_d_eop;
        end

        w_perr = (w_start & w_open) | (r_d_en & r_d_eop & ~r_d_sop & ~w_open);

        w_load     = w_close & (~res_valid | res_ready);
        w_drop_nxt = drop_cnt;
        if (w_close && !w_load && !(&drop_cnt)) w_drop_nxt = drop_cnt + CNT_W'(1);

        if (w_load)                      w_valid_nxt = 1'b1;
        else if (res_valid && res_ready) w_valid_nxt = 1'b0;
        else                             w_valid_nxt = res_valid;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_d_en           <= 1'b0;
            r_d_sop          <= 1'b0;
            r_d_eop          <= 1'b0;
            r_mask           <= '0;
            r_cnt            <= '0;
            r_found          <= 1'b0;
            r_first_br       <= '0;
            r_first_off      <= '0;
            r_off            <= '0;
            res_valid        <= 1'b0;
            res_hit_mask     <= '0;
            res_first_branch <= '0;
            res_first_offset <= '0;
            res_hit_count    <= '0;
            drop_cnt         <= '0;
            proto_err        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_d_en      <= en;
            r_d_sop     <= sop;
            r_d_eop     <= eop;
            r_mask      <= w_mask_nxt;
            r_cnt       <= w_cnt_nxt;
            r_found     <= w_found_nxt;
            r_first_br  <= w_first_br_nxt;
            r_first_off <= w_first_off_nxt;
            r_off       <= w_off_nxt;
            res_valid   <= w_valid_nxt;
            drop_cnt    <= w_drop_nxt;
            proto_err   <= w_perr;
            if (w_load) begin
                res_hit_mask     <= w_mask_nxt;
                res_first_branch <= w_first_br_nxt;
                res_first_offset <= w_first_off_nxt;
                res_hit_count    <= w_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_repeat_nfa_match_report.sv
// Bench for repeat_nfa_match_report: packet-level queue model checked every cycle,
// directed scenarios with literal expectations, then randomized framing/backpressure.
module tb_repeat_nfa_match_report;

    localparam int unsigned NB = 4;
    localparam int unsigned BW = 2;
    localparam int unsigned OW = 16;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en, sop, eop, res_ready;
    logic [NB-1:0] bm;
    logic          res_valid, proto_err;
    logic [NB-1:0] res_hit_mask;
    logic [BW-1:0] res_first_branch;
    logic [OW-1:0] res_first_offset;
    logic [CW-1:0] res_hit_count, drop_cnt;

    always #5 clk = ~clk;

    repeat_nfa_match_report #(.NUM_BRANCH(NB), .BR_W(BW), .OFFSET_W(OW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .sop(sop), .eop(eop),
        .branch_match(bm), .res_valid(res_valid), .res_ready(res_ready),
        .res_hit_mask(res_hit_mask), .res_first_branch(res_first_branch),
        .res_first_offset(res_first_offset), .res_hit_count(res_hit_count),
        .drop_cnt(drop_cnt), .proto_err(proto_err)
    );

    int checks = 0;
    int errors = 0;

    // Model: open packet kept as a queue of per-byte match vectors
    bit            m_open;
    logic [NB-1:0] m_q[$];
    logic          m_valid, m_perr;
    logic [NB-1:0] m_mask;
    logic [BW-1:0] m_fb;
    logic [OW-1:0] m_fo;
    logic [CW-1:0] m_cnt, m_drop;
    logic          p_en, p_sop, p_eop;
    bit            chk_on = 1'b0;
    logic [NB-1:0] carry;
    logic [NB-1:0] hits[0:127];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_q.delete();
        m_valid = 0; m_perr = 0; m_mask = '0; m_fb = '0; m_fo = '0; m_cnt = '0; m_drop = '0;
        p_en = 0; p_sop = 0; p_eop = 0;
    endtask

    // Summarise the whole packet from its byte list
    task automatic model_record();
        int  sum;
        bit  found;
        sum = 0; found = 0;
        m_mask = '0; m_fb = '0; m_fo = '0;
        foreach (m_q[i]) begin
            m_mask |= m_q[i];
            sum += $countones(m_q[i]);
            if (!found && m_q[i] != '0) begin
                found = 1;
                m_fo = (i > 65535) ? 16'hFFFF : OW'(i);
                for (int b = 0; b < int'(NB); b++)
                    if (m_q[i][b]) begin m_fb = BW'(b); break; end
            end
        end
        m_cnt = (sum > 255) ? 8'hFF : CW'(sum);
    endtask

    // One clock edge: byte presented last cycle meets the match vector of this cycle
    task automatic model_edge(input logic [NB-1:0] b, input logic rdy);
        bit loaded, perr;
        loaded = 0; perr = 0;
        if (p_en) begin
            if (p_sop) begin
                if (m_open) perr = 1;
                m_q.delete();
                m_open = 1;
                m_q.push_back(b);
            end else if (m_open) begin
                m_q.push_back(b);
            end else if (p_eop) begin
                perr = 1;
            end
            if (m_open && p_eop) begin
                m_open = 0;
                if (!m_valid || rdy) begin
                    model_record();
                    m_valid = 1;
                    loaded = 1;
                end else if (m_drop != 8'hFF) begin
                    m_drop = m_drop + 8'd1;
                end
                m_q.delete();
            end
        end
        if (!loaded && m_valid && rdy) m_valid = 0;
        m_perr = perr;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("res_valid", 32'(res_valid), 32'(m_valid));
            chk("proto_err", 32'(proto_err), 32'(m_perr));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (m_valid) begin
                chk("res_hit_mask", 32'(res_hit_mask), 32'(m_mask));
                chk("res_hit_count", 32'(res_hit_count), 32'(m_cnt));
                chk("res_first_branch", 32'(res_first_branch), 32'(m_fb));
                chk("res_first_offset", 32'(res_first_offset), 32'(m_fo));
            end
        end
    end

    task automatic step(input logic e, input logic s, input logic p,
                        input logic [NB-1:0] b, input logic rdy);
        en = e; sop = s; eop = p; bm = b; res_ready = rdy;
        @(posedge clk);
        model_edge(b, rdy);
        p_en = e; p_sop = s; p_eop = p;
        #1;
    endtask

    task automatic pkt(input int len, input logic rdy, input bit tail);
        for (int i = 0; i < len; i++)
            step(1'b1, i == 0, i == len - 1, (i == 0) ? carry : hits[i-1], rdy);
        if (tail) begin
            step(1'b0, 1'b0, 1'b0, hits[len-1], rdy);
            carry = '0;
        end else begin
            carry = hits[len-1];
        end
    endtask

    task automatic clear_hits();
        for (int i = 0; i < 128; i++) hits[i] = '0;
    endtask

    task automatic drain();
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic chk_rec(input string tag, input logic [NB-1:0] mk, input logic [CW-1:0] c,
                           input logic [BW-1:0] fb, input logic [OW-1:0] fo);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_mask"}, 32'(res_hit_mask), 32'(mk));
        chk({tag, "_count"}, 32'(res_hit_count), 32'(c));
        chk({tag, "_fbranch"}, 32'(res_first_branch), 32'(fb));
        chk({tag, "_foffset"}, 32'(res_first_offset), 32'(fo));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_mask"}, 32'(res_hit_mask), 32'd0);
        chk({tag, "_count"}, 32'(res_hit_count), 32'd0);
        chk({tag, "_fbranch"}, 32'(res_first_branch), 32'd0);
        chk({tag, "_foffset"}, 32'(res_first_offset), 32'd0);
        chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
        chk({tag, "_perr"}, 32'(proto_err), 32'd0);
    endtask

    initial begin
        bit            g_open;
        logic          e, s, p;
        logic [NB-1:0] b;

        reset_n = 1'b0; en = 0; sop = 0; eop = 0; bm = '0; res_ready = 0; carry = '0;
        model_reset();
        clear_hits();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        chk_on = 1'b1;

        // abc packet, branch 2 hits on 'c'
        clear_hits(); hits[2] = 4'b0100;
        pkt(3, 1'b1, 1'b1);
        chk_rec("abc", 4'b0100, 8'd1, 2'd2, 16'd2);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("abc_accepted", 32'(res_valid), 32'd0);

        // simultaneous hits
        clear_hits(); hits[5] = 4'b1010; hits[7] = 4'b0001;
        pkt(10, 1'b1, 1'b1);
        chk_rec("simul", 4'b1011, 8'd3, 2'd1, 16'd5);
        drain();

        // zero-hit packet still yields a record
        clear_hits();
        pkt(2, 1'b1, 1'b1);
        chk_rec("nohit", 4'b0000, 8'd0, 2'd0, 16'd0);
        drain();

        // backpressure: second record dropped
        clear_hits(); hits[1] = 4'b0001;
        pkt(3, 1'b0, 1'b0);
        clear_hits(); hits[0] = 4'b0010;
        pkt(2, 1'b0, 1'b1);
        chk_rec("bp", 4'b0001, 8'd1, 2'd0, 16'd1);
        chk("bp_drop", 32'(drop_cnt), 32'd1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("bp_accepted", 32'(res_valid), 32'd0);
        drain();

        // framing: sop inside an open packet
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b1, '0, 1'b0);
        chk("frm_perr_pulse", 32'(proto_err), 32'd1);
        step(1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
        chk("frm_perr_low", 32'(proto_err), 32'd0);
        chk_rec("frm", 4'b0010, 8'd1, 2'd1, 16'd1);
        chk("frm_drop", 32'(drop_cnt), 32'd1);
        drain();
        // eop without sop while idle
        step(1'b1, 1'b0, 1'b1, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("lone_eop_perr", 32'(proto_err), 32'd1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("lone_eop_norec", 32'(res_valid), 32'd0);

        // hit-count saturation
        clear_hits();
        for (int i = 0; i < 100; i++) hits[i] = 4'b1111;
        pkt(100, 1'b0, 1'b1);
        chk_rec("sat", 4'b1111, 8'd255, 2'd0, 16'd0);

        // reset while a record is pending and a packet is open
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
        #2;
        chk_on = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        en = 0; sop = 0; eop = 0; bm = '0; res_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_on = 1'b1;
        clear_hits(); hits[3] = 4'b0001; carry = '0;
        pkt(4, 1'b1, 1'b1);
        chk_rec("postrst", 4'b0001, 8'd1, 2'd0, 16'd3);
        chk("postrst_drop", 32'(drop_cnt), 32'd0);
        drain();

        // randomized framing, sparse matches and backpressure
        g_open = 0;
        for (int c = 0; c < 4000; c++) begin
            s = 0; p = 0;
            if (g_open) begin
                e = ($urandom_range(0, 9) < 7);
                if (e) begin
                    s = ($urandom_range(0, 99) < 3);
                    p = ($urandom_range(0, 99) < 20);
                end
            end else begin
                e = ($urandom_range(0, 1) == 1);
                if (e) begin
                    if ($urandom_range(0, 99) < 85) begin
                        s = 1;
                        p = ($urandom_range(0, 99) < 10);
                    end else begin
                        p = ($urandom_range(0, 1) == 1);
                    end
                end
            end
            if (e && s) g_open = 1;
            if (e && p && g_open) g_open = 0;
            b = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
            step(e, s, p, b, $urandom_range(0, 1) == 1);
        end
        drain();
        chk_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/repeat_nfa_match_report.md
Name: repeat_nfa_match_report

Overview:
Downstream stage of the NFA branch chains. It consumes the per-branch `match` outputs of up to NUM_BRANCH parallel branches, together with packet framing aligned to the payload byte stream. For each packet it accumulates a hit mask, a total hit count and the first-hit branch and byte offset. At end of packet it presents one result record on a valid/ready interface to the host-side result logic.

Parameters:
NUM_BRANCH, 4, number of branch match inputs (1..16)
BR_W, 2, width of branch index; must equal ceil(log2(NUM_BRANCH)), minimum 1
OFFSET_W, 16, byte-offset width
CNT_W, 8, hit-counter and drop-counter width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
en  in  1  payload byte valid; the same signal that drives the branch chains
sop  in  1  first byte of packet; qualified by en
eop  in  1  last byte of packet; qualified by en
branch_match  in  NUM_BRANCH  bit i = match output of branch i
res_valid  out  1  result record valid
res_ready  in  1  consumer accepts record
res_hit_mask  out  NUM_BRANCH  branches that hit at least once in the packet
res_first_branch  out  BR_W  lowest-index branch of the earliest hit
res_first_offset  out  OFFSET_W  0-based byte offset of the final byte of the earliest hit
res_hit_count  out  CNT_W  total hit events, saturating
drop_cnt  out  CNT_W  records lost because the result slot was occupied, saturating
proto_err  out  1  one-cycle pulse on a framing violation

Behaviour:
- Clock and reset: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset values: all outputs 0. State returns to IDLE. All accumulators, the byte counter and the result slot are cleared.
- Alignment:
  - Each branch's match is registered, so branch_match at cycle t refers to the byte presented at t-1.
  - en, sop and eop are registered once internally (d_en, d_sop, d_eop) and used only in delayed form.
  - A branch_match bit counts only when d_en=1 in the same cycle and the packet is open; otherwise it is ignored.
- Byte offset counter:
  - Loads 0 on d_en&d_sop.
  - Increments on each subsequent d_en byte.
  - Saturates at 2^OFFSET_W-1 and does not wrap.
- States:
  - IDLE: waiting for d_en&d_sop. On it, clear the accumulators, go to ACCUM, and evaluate hits for that byte.
  - ACCUM:
    - Per d_en byte: hit_mask |= branch_match.
    - hit_count += popcount(branch_match), saturating.
    - On the first byte with any bit set: record offset and the lowest set index as first branch.
    - d_en&d_eop: accumulate that byte, then close the packet. Go to IDLE.
    - d_sop&d_eop on the same byte: single-byte packet; open and close in one cycle.
- Close / result slot:
  - At close, if the slot is empty (res_valid=0) or is being accepted this cycle (res_valid&res_ready): load the record and set res_valid=1 next cycle.
  - Otherwise discard the record and increment drop_cnt (saturating).
  - Packets with zero hits still produce a record: mask 0, count 0, first_branch 0, first_offset 0.
- Handshake:
  - res_valid stays high and the record is held stable until res_valid&res_ready.
  - res_valid falls the cycle after acceptance, unless a new record loads in that same cycle.
  - res_ready while res_valid=0 has no effect.
- Framing errors:
  - d_en&d_sop while in ACCUM: pulse proto_err, discard the open packet with no record and no drop count, and restart accumulation on the new byte.
  - d_en&d_eop in IDLE without sop: pulse proto_err and ignore the byte.
- Reset mid-packet or mid-handshake: everything is cleared immediately and asynchronously. The pending record is lost, and drop_cnt is not incremented.
- Latency: res_valid rises 2 cycles after the en cycle carrying eop (one cycle alignment, one cycle record load).

Test Plan:
1. Three-byte packet "abc" (NUM_BRANCH=4): en with sop on 'a', eop on 'c'; branch 2 matches one cycle after 'c', res_ready=1 -> res_valid high 2 cycles after the eop cycle; mask=4'b0100, count=1, first_branch=2, first_offset=2.
2. Simultaneous hits: branches 1 and 3 hit on byte offset 5, branch 0 on offset 7, 10-byte packet -> mask=4'b1011, count=3, first_branch=1, first_offset=5.
3. Backpressure: res_ready=0 while two back-to-back packets close -> first record held stable, second dropped, drop_cnt=1; raise res_ready -> first record accepted, res_valid=0.
4. Framing: sop, 3 bytes, sop again without eop, then 2 bytes with eop, one hit on the second packet's byte 1 -> proto_err single pulse; one record with first_offset=1, count=1.
5. Saturation: CNT_W=8, all 4 branches hitting on each of 100 bytes -> res_hit_count=255.
6. Reset: assert reset_n=0 while res_valid=1 and a packet is open -> all outputs 0 immediately; next clean packet reports normally with drop_cnt=0.
